// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix types: HTRANS encodings, matrix port ids, HMASTER width.
// Also carries the burst-continuation test used by the output-stage arbiter.
package ahb_mtx_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      PORT_NONE = 2'd0,
      PORT_P0   = 2'd1,
      PORT_P1   = 2'd2
   } port_e;

   localparam int HMASTER_W = 4;

   // SEQ and BUSY both mean the owner is still inside a burst.
   function automatic logic htrans_cont(input logic [1:0] trans);
      return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
   endfunction

endpackage

// File: rtl/ahb_mtx_arb_rr.sv
// Two-requester round-robin picker; purely combinational, registers live in the caller.
// A holding owner always wins; otherwise the port other than last_grant breaks a tie.
module ahb_mtx_arb_rr
   import ahb_mtx_pkg::*;
(
   input  logic [1:0] req,
   input  logic [1:0] hold,
   input  port_e      last_grant,
   output port_e      next_grant
);

   always_comb begin
      next_grant = PORT_NONE;
      if (hold[0]) begin
         next_grant = PORT_P0;
      end else if (hold[1]) begin
         next_grant = PORT_P1;
      end else if (&req) begin
         next_grant = (last_grant == PORT_P0) ? PORT_P1 : PORT_P0;
      end else if (req[0]) begin
         next_grant = PORT_P0;
      end else if (req[1]) begin
         next_grant = PORT_P1;
      end
   end

endmodule

// File: rtl/ahb_mtx_out_arbiter.sv
// AHB matrix output stage: round-robin with burst hold over two input ports, one slave side.
// Latency: grant registered at the request edge, address phase on the next cycle.
// Backpressure: HREADYOUTM=0 freezes all state; AHB_MTX_OUT_LOCK_EN adds HMASTLOCK hold.
module ahb_mtx_out_arbiter
   import ahb_mtx_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic                 sel_op0,
   input  logic [ADDR_W-1:0]    addr_op0,
   input  logic [1:0]           trans_op0,
   input  logic                 write_op0,
   input  logic [2:0]           size_op0,
   input  logic [2:0]           burst_op0,
   input  logic [3:0]           prot_op0,
   input  logic                 mastlock_op0,
   input  logic [DATA_W-1:0]    wdata_op0,
   output logic                 active_op0,
   input  logic                 sel_op1,
   input  logic [ADDR_W-1:0]    addr_op1,
   input  logic [1:0]           trans_op1,
   input  logic                 write_op1,
   input  logic [2:0]           size_op1,
   input  logic [2:0]           burst_op1,
   input  logic [3:0]           prot_op1,
   input  logic                 mastlock_op1,
   input  logic [DATA_W-1:0]    wdata_op1,
   output logic                 active_op1,
   input  logic                 HREADYOUTM,
   output logic                 HREADYMUXM,
   output logic                 HSELM,
   output logic [ADDR_W-1:0]    HADDRM,
   output logic [1:0]           HTRANSM,
   output logic                 HWRITEM,
   output logic [2:0]           HSIZEM,
   output logic [2:0]           HBURSTM,
   output logic [3:0]           HPROTM,
   output logic                 HMASTLOCKM,
   output logic [HMASTER_W-1:0] HMASTERM,
   output logic [DATA_W-1:0]    HWDATAM
);

   port_e      addr_port;
   port_e      data_port;
   port_e      last_grant;
   port_e      next_grant;
   logic [1:0] req;
   logic [1:0] hold;
   logic       lock_op0;
   logic       lock_op1;

`ifdef AHB_MTX_OUT_LOCK_EN
   assign lock_op0 = mastlock_op0;
   assign lock_op1 = mastlock_op1;
`else
   logic unused_mastlock;
   assign unused_mastlock = mastlock_op0 ^ mastlock_op1;
   assign lock_op0        = 1'b0;
   assign lock_op1        = 1'b0;
`endif

   assign req[0]  = sel_op0 & (trans_op0 != HTRANS_IDLE);
   assign req[1]  = sel_op1 & (trans_op1 != HTRANS_IDLE);
   assign hold[0] = (addr_port == PORT_P0) & sel_op0 & (htrans_cont(trans_op0) | lock_op0);
   assign hold[1] = (addr_port == PORT_P1) & sel_op1 & (htrans_cont(trans_op1) | lock_op1);

   ahb_mtx_arb_rr u_arb_rr (
      .req        (req),
      .hold       (hold),
      .last_grant (last_grant),
      .next_grant (next_grant)
   );

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         addr_port  <= PORT_NONE;
         data_port  <= PORT_NONE;
         last_grant <= PORT_P1;
      end else if (HREADYOUTM) begin
         addr_port <= next_grant;
         data_port <= (HTRANSM != HTRANS_IDLE) ? addr_port : PORT_NONE;
         if (next_grant != PORT_NONE) begin
            last_grant <= next_grant;
         end
      end
   end

   assign active_op0 = (addr_port == PORT_P0);
   assign active_op1 = (addr_port == PORT_P1);
   assign HREADYMUXM = HREADYOUTM;

   always_comb begin
      HSELM      = 1'b0;
      HADDRM     = '0;
      HTRANSM    = HTRANS_IDLE;
      HWRITEM    = 1'b0;
      HSIZEM     = '0;
      HBURSTM    = '0;
      HPROTM     = '0;
      HMASTLOCKM = 1'b0;
      HMASTERM   = '0;
      case (addr_port)
         PORT_P0: begin
            HSELM      = sel_op0;
            HADDRM     = addr_op0;
            HTRANSM    = trans_op0;
            HWRITEM    = write_op0;
            HSIZEM     = size_op0;
            HBURSTM    = burst_op0;
            HPROTM     = prot_op0;
            HMASTLOCKM = lock_op0;
            HMASTERM   = HMASTER_W'(0);
         end
         PORT_P1: begin
            HSELM      = sel_op1;
            HADDRM     = addr_op1;
            HTRANSM    = trans_op1;
            HWRITEM    = write_op1;
            HSIZEM     = size_op1;
            HBURSTM    = burst_op1;
            HPROTM     = prot_op1;
            HMASTLOCKM = lock_op1;
            HMASTERM   = HMASTER_W'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      HWDATAM = '0;
      case (data_port)
         PORT_P0: HWDATAM = wdata_op0;
         PORT_P1: HWDATAM = wdata_op1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahb_mtx_out_arbiter.sv
// Bench for ahb_mtx_out_arbiter: directed scenarios then random traffic against a reference model.
module tb_ahb_mtx_out_arbiter;

`ifdef AHB_MTX_OUT_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        HREADYOUTM = 1'b1;
   logic        sel   [2] = '{1'b0, 1'b0};
   logic [31:0] addr  [2] = '{32'd0, 32'd0};
   logic [1:0]  trans [2] = '{2'd0, 2'd0};
   logic        write [2] = '{1'b0, 1'b0};
   logic [2:0]  size  [2] = '{3'd0, 3'd0};
   logic [2:0]  burst [2] = '{3'd0, 3'd0};
   logic [3:0]  prot  [2] = '{4'd0, 4'd0};
   logic        mlock [2] = '{1'b0, 1'b0};
   logic [31:0] wdata [2] = '{32'd0, 32'd0};

   logic        active_op0, active_op1, HREADYMUXM, HSELM, HWRITEM, HMASTLOCKM;
   logic [31:0] HADDRM, HWDATAM;
   logic [1:0]  HTRANSM;
   logic [2:0]  HSIZEM, HBURSTM;
   logic [3:0]  HPROTM, HMASTERM;

   int errs = 0;
   int checks = 0;
   // Reference state: owner of address phase, owner of data phase (-1 = nobody), last granted port.
   int m_own = -1;
   int m_dat = -1;
   int m_last = 1;

   always #5 HCLK = ~HCLK;

   ahb_mtx_out_arbiter dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .sel_op0(sel[0]), .addr_op0(addr[0]), .trans_op0(trans[0]), .write_op0(write[0]),
      .size_op0(size[0]), .burst_op0(burst[0]), .prot_op0(prot[0]), .mastlock_op0(mlock[0]),
      .wdata_op0(wdata[0]), .active_op0(active_op0),
      .sel_op1(sel[1]), .addr_op1(addr[1]), .trans_op1(trans[1]), .write_op1(write[1]),
      .size_op1(size[1]), .burst_op1(burst[1]), .prot_op1(prot[1]), .mastlock_op1(mlock[1]),
      .wdata_op1(wdata[1]), .active_op1(active_op1),
      .HREADYOUTM(HREADYOUTM), .HREADYMUXM(HREADYMUXM), .HSELM(HSELM), .HADDRM(HADDRM),
      .HTRANSM(HTRANSM), .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM),
      .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM), .HMASTERM(HMASTERM), .HWDATAM(HWDATAM)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_port(input int p, input logic s, input logic [1:0] t, input logic ml);
      sel[p]   = s;
      trans[p] = t;
      mlock[p] = ml;
      addr[p]  = $urandom;
      wdata[p] = $urandom;
      write[p] = 1'($urandom);
      size[p]  = 3'($urandom);
      burst[p] = 3'($urandom);
      prot[p]  = 4'($urandom);
   endtask

   task automatic check_outputs();
      int o;
      o = m_own;
      chk("active0", active_op0, m_own == 0);
      chk("active1", active_op1, m_own == 1);
      chk("hreadymux", HREADYMUXM, HREADYOUTM);
      chk("hwdata", HWDATAM, (m_dat >= 0) ? wdata[m_dat] : 32'd0);
      if (o >= 0) begin
         chk("hsel", HSELM, sel[o]);
         chk("haddr", HADDRM, addr[o]);
         chk("htrans", HTRANSM, trans[o]);
         chk("hwrite", HWRITEM, write[o]);
         chk("hsize", HSIZEM, size[o]);
         chk("hburst", HBURSTM, burst[o]);
         chk("hprot", HPROTM, prot[o]);
         chk("hmastlock", HMASTLOCKM, LOCK ? mlock[o] : 1'b0);
         chk("hmaster", HMASTERM, o);
      end else begin
         chk("idle_ctrl", {HSELM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM, HMASTERM}, 0);
         chk("idle_haddr", HADDRM, 0);
      end
   endtask

   // Arbitration rules applied to the inputs present at a clock edge.
   task automatic model_edge(input logic rdy, input logic rst);
      bit r0, r1, held;
      int nxt;
      if (rst) begin
         m_own = -1; m_dat = -1; m_last = 1;
      end else if (rdy) begin
         r0 = sel[0] && trans[0] != 2'd0;
         r1 = sel[1] && trans[1] != 2'd0;
         held = (m_own >= 0) && sel[m_own] &&
                (trans[m_own] == 2'd1 || trans[m_own] == 2'd3 || (LOCK && mlock[m_own]));
         if (held) nxt = m_own;
         else if (r0 && r1) nxt = 1 - m_last;
         else if (r0) nxt = 0;
         else if (r1) nxt = 1;
         else nxt = -1;
         m_dat = (m_own >= 0 && trans[m_own] != 2'd0) ? m_own : -1;
         m_own = nxt;
         if (nxt >= 0) m_last = nxt;
      end
   endtask

   task automatic step(input logic rdy, input logic rst);
      HREADYOUTM = rdy;
      HRESET = rst;
      #1 check_outputs();
      @(posedge HCLK);
      model_edge(rdy, rst);
      @(negedge HCLK);
      #1;
   endtask

   task automatic both_idle();
      set_port(0, 1'b0, 2'd0, 1'b0);
      set_port(1, 1'b0, 2'd0, 1'b0);
   endtask

   initial begin
      // Initial reset, state is unknown before it so nothing is compared yet.
      both_idle();
      @(posedge HCLK);
      model_edge(1'b1, 1'b1);
      @(negedge HCLK);
      #1;
      step(1'b1, 1'b1);
      chk("rst_state", {active_op0, active_op1, HSELM, HTRANSM}, 0);
      chk("rst_hwdata", HWDATAM, 0);

      // Single NONSEQ from P0.
      set_port(0, 1'b1, 2'd2, 1'b0);
      addr[0] = 32'h2000_0000;
      wdata[0] = 32'hA5A5_0001;
      step(1'b1, 1'b0);
      chk("a_active0", active_op0, 1'b1);
      chk("a_haddr", HADDRM, 32'h2000_0000);
      chk("a_hmaster", HMASTERM, 4'd0);
      step(1'b1, 1'b0);
      chk("a_hwdata", HWDATAM, 32'hA5A5_0001);

      // Simultaneous requests, zero-gap hand-over, fresh re-request.
      both_idle();
      step(1'b1, 1'b1);
      set_port(0, 1'b1, 2'd2, 1'b0);
      set_port(1, 1'b1, 2'd2, 1'b0);
      step(1'b1, 1'b0);
      chk("b_first_p0", active_op0, 1'b1);
      set_port(0, 1'b1, 2'd0, 1'b0);
      set_port(1, 1'b1, 2'd2, 1'b0);
      step(1'b1, 1'b0);
      chk("b_handover_p1", active_op1, 1'b1);
      set_port(0, 1'b1, 2'd2, 1'b0);
      set_port(1, 1'b1, 2'd2, 1'b0);
      step(1'b1, 1'b0);
      chk("b_back_p0", active_op0, 1'b1);

      // INCR4 by P0 is never split by P1.
      both_idle();
      step(1'b1, 1'b1);
      set_port(0, 1'b1, 2'd2, 1'b0);
      step(1'b1, 1'b0);
      set_port(0, 1'b1, 2'd2, 1'b0);
      step(1'b1, 1'b0);
      foreach (trans[i]) begin end
      for (int b = 0; b < 4; b++) begin
         set_port(0, 1'b1, (b == 1) ? 2'd1 : 2'd3, 1'b0);
         set_port(1, 1'b1, 2'd2, 1'b0);
         step(1'b1, 1'b0);
         chk("c_no_split", active_op1, 1'b0);
      end
      set_port(0, 1'b1, 2'd0, 1'b0);
      set_port(1, 1'b1, 2'd2, 1'b0);
      step(1'b1, 1'b0);
      chk("c_p1_after_burst", active_op1, 1'b1);

      // Wait states during P1's data phase while P0 requests.
      set_port(0, 1'b0, 2'd0, 1'b0);
      set_port(1, 1'b1, 2'd2, 1'b0);
      wdata[1] = 32'h1234_5678;
      step(1'b1, 1'b0);
      set_port(0, 1'b1, 2'd2, 1'b0);
      trans[1] = 2'd0;
      for (int w = 0; w < 3; w++) begin
         step(1'b0, 1'b0);
         chk("d_hold_owner", active_op1, 1'b1);
         chk("d_hold_wdata", HWDATAM, 32'h1234_5678);
      end
      step(1'b1, 1'b0);
      chk("d_p0_granted", active_op0, 1'b1);

      // Reset in the middle of a P1 burst.
      both_idle();
      step(1'b1, 1'b1);
      set_port(1, 1'b1, 2'd2, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      set_port(1, 1'b1, 2'd3, 1'b0);
      step(1'b1, 1'b0);
      set_port(1, 1'b1, 2'd3, 1'b0);
      step(1'b1, 1'b1);
      chk("e_outputs_clear", {active_op1, HSELM, HTRANSM, HMASTERM}, 0);
      chk("e_hwdata_clear", HWDATAM, 0);
      set_port(0, 1'b1, 2'd2, 1'b0);
      set_port(1, 1'b1, 2'd2, 1'b0);
      step(1'b1, 1'b0);
      chk("e_p0_wins", active_op0, 1'b1);

      // Locked sequence from P1 while P0 requests.
      both_idle();
      step(1'b1, 1'b1);
      set_port(1, 1'b1, 2'd2, 1'b1);
      step(1'b1, 1'b0);
      chk("f_hmastlock", HMASTLOCKM, LOCK);
      set_port(1, 1'b1, 2'd2, 1'b1);
      step(1'b1, 1'b0);
      set_port(0, 1'b1, 2'd2, 1'b0);
      set_port(1, 1'b1, 2'd0, 1'b1);
      step(1'b1, 1'b0);
      chk("f_idle_release", active_op0, !LOCK);
      set_port(0, 1'b1, 2'd2, 1'b0);
      set_port(1, 1'b1, 2'd2, 1'b1);
      step(1'b1, 1'b0);
      set_port(0, 1'b1, 2'd2, 1'b0);
      set_port(1, 1'b1, 2'd0, 1'b0);
      step(1'b1, 1'b0);
      chk("f_unlock_p0", active_op0, 1'b1);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         for (int p = 0; p < 2; p++) begin
            set_port(p, ($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 3) == 0));
         end
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ahb_mtx_out_arbiter.md
# ahb_mtx_out_arbiter

Output-stage arbiter for the AHB bus matrix: the slave-side counterpart of the per-input decoders. It collects select and address-phase controls from two matrix input ports and arbitrates them round-robin with burst hold. It drives one AHB-Lite master interface towards a single slave and muxes write data by data-phase owner. It returns a per-port `active_opN` flag, which the decoder uses to know whether its transfer is on the bus or must be held.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, write-data width.
- HCLK  in  1  AHB clock; all state updates on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- sel_opN  in  1  (N=0,1) decoder select for this output stage.
- addr_opN  in  ADDR_W  address.
- trans_opN  in  2  HTRANS.
- write_opN  in  1  HWRITE.
- size_opN  in  3  HSIZE.
- burst_opN  in  3  HBURST.
- prot_opN  in  4  HPROT.
- mastlock_opN  in  1  HMASTLOCK.
- wdata_opN  in  DATA_W  write data, valid in data phase.
- active_opN  out  1  port N owns the current address phase.
- HREADYOUTM  in  1  slave ready.
- HREADYMUXM  out  1  HREADY to slave; equals HREADYOUTM.
- HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM  out  1/ADDR_W/2/1/3/3/4/1  muxed address-phase controls.
- HMASTERM  out  4  owner id, {3'b0,N}.
- HWDATAM  out  DATA_W  write data of the data-phase owner.

## Operation
- req_N = sel_opN & (trans_opN != IDLE).
- State: addr_port ∈ {NONE, P0, P1}, data_port ∈ {NONE, P0, P1}, last_grant ∈ {P0, P1}.
- Address outputs are muxed from addr_port. For NONE: HSELM=0, HTRANSM=IDLE, all other address outputs 0.
- active_opN = (addr_port == PN).
- Rearbitration occurs only on edges with HREADYOUTM=1:
  - Hold: the owner keeps the grant while it presents SEQ or BUSY with sel high, so bursts are never split.
  - Otherwise, grant goes to the requesting port. If both request, the port ≠ last_grant wins. If neither requests, grant goes to NONE.
  - last_grant is updated on every grant to P0/P1.
- The owner presenting IDLE, or deasserting sel, releases the grant at that edge. An owner that still has a NONSEQ request competes normally.
- data_port <= (HTRANSM != IDLE) ? addr_port : NONE on each edge with HREADYOUTM=1.
- HWDATAM is muxed by data_port; it is 0 for NONE.
- When HREADYOUTM=0, all state holds and the address outputs of the owner pass through unchanged.

## Timing
- Reset (synchronous): addr_port=NONE, data_port=NONE, last_grant=P1, so P0 has first priority. All outputs go to 0 the cycle after HRESET is sampled high. HREADYMUXM follows HREADYOUTM combinationally.
- Grant latency: a request with the bus free in cycle k registers its grant at the end of k. active_opN and the address phase appear in k+1. The decoder holds the transfer meanwhile.
- Hand-over between ports: zero idle cycles when the old owner ends with NONSEQ/IDLE and another port requests on the same ready edge.
- Wait states: no grant change while HREADYOUTM=0, even if the owner drops its request. The new value is sampled at the next ready edge.
- Simultaneous release and request by the same port: treated as a fresh request; it wins only if the other port is not requesting or last_grant ≠ this port.
- Reset mid-burst: state is cleared at the edge. No burst continuation is required afterwards.

## Configuration
- AHB_MTX_OUT_LOCK_EN defined:
  - An owner with mastlock_opN=1 keeps the grant across NONSEQ and IDLE until it presents mastlock_opN=0 on a ready edge.
  - HMASTLOCKM is muxed from the owner.
- Not defined:
  - mastlock inputs are ignored and HMASTLOCKM=0.
  - The lock hold term is absent.

## Structure
- Shared package ahb_mtx_pkg holds:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - Port-id enum NONE/P0/P1.
  - HMASTER width constant.
- One sub-module, ahb_mtx_arb_rr: a two-requester round-robin picker with inputs req, hold, last_grant and output next_grant. It is purely combinational; the registers live in the top.

## Test plan
- Reset, then P0 NONSEQ to 0x2000_0000 with HREADYOUTM=1: active_op0=1 and HADDRM=0x2000_0000 next cycle, HMASTERM=0; HWDATAM=wdata_op0 one cycle later.
- P0 and P1 request NONSEQ in the same cycle after reset: P0 granted first; on P0's IDLE, P1 granted with no idle gap; then P0 again on a fresh simultaneous request.
- P0 INCR4 (NONSEQ + 3 SEQ, one BUSY) with P1 requesting throughout: P1 is not granted until the ready edge after the last SEQ.
- Slave inserts 3 wait states (HREADYOUTM=0) during P1's data phase while P0 requests: addr_port, data_port and HWDATAM stay stable; P0 is granted at the first ready edge.
- HRESET pulsed mid-INCR4 owned by P1: all outputs 0 next cycle; P0 then wins a simultaneous request.
- With AHB_MTX_OUT_LOCK_EN: P1 locked NONSEQ, IDLE, NONSEQ while P0 requests: P1 holds the grant until mastlock_op1=0. Without the macro, P0 is granted after P1's first IDLE and HMASTLOCKM stays 0.
